neuron_writeback: RTL

- Write-side counterpart of the address generator / MAC read path: takes each finished neuron result from the MAC core, applies the activation, and writes it into the neuron dual-port RAM write port.
- Per layer: latches Nk and the write base, counts neurons, buffers results in a small FIFO so RAM-port stalls never lose data, and pulses layer_done once the last neuron is in RAM.
- Sits between MAC_Core.out and Neuron_DP_RAM.write_address/write_data/wre; the control unit uses layer_done to advance the instruction pointer and swap read/write bases.

---
 rtl/neuron_writeback_pkg.sv | 24 ++
 rtl/neuron_writeback_wb_fifo.sv | 67 ++++++
 rtl/neuron_writeback.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/neuron_writeback_pkg.sv
// ==========================================================================
// neuron_writeback_pkg : shared state encoding and defaults for write-back
// Rev 1.0
// ==========================================================================
`default_nettype none

package neuron_writeback_pkg;

   localparam int DATA_W_DFLT = 8;
   localparam int ADDR_W_DFLT = 8;

   // Activation select, shared with the MAC core configuration
   localparam bit ACT_RELU = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/neuron_writeback_wb_fifo.sv
// ==========================================================================
// wb_fifo : first-word-fall-through result buffer, pop frees a slot same cycle
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic                            pop,
   input  logic [DATA_W-1:0]               wdata,
   output logic [DATA_W-1:0]               rdata,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              do_push, do_pop;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)
         count_d = count_q + (PTR_W+1)'(1);
      else if (do_pop && !do_push)
         count_d = count_q - (PTR_W+1)'(1);
   end

   // Storage needs no reset: occupancy is tracked entirely by the pointers
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/neuron_writeback.sv
// ==========================================================================
// neuron_writeback : activates MAC results and writes a layer into neuron RAM
// Rev 1.0
// ==========================================================================
`default_nettype none

module neuron_writeback
   import neuron_writeback_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DFLT,
   parameter int ADDR_W     = ADDR_W_DFLT,
   parameter int FIFO_DEPTH = 4,
   parameter bit RELU_EN    = ACT_RELU
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              layer_start,
   input  logic [ADDR_W-1:0] Nk,
   input  logic [ADDR_W-1:0] write_base,
   input  logic              mac_valid,
   input  logic [DATA_W-1:0] mac_data,
   input  logic              wr_stall,
   output logic              wre,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              layer_done,
   output logic              overflow_err
);

   wb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] nk_q, nk_d, base_q, base_d;
   logic [ADDR_W-1:0] acc_q, acc_d, idx_q, idx_d, acc_inc;
   logic              wre_q, wre_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, act_value, fifo_rdata;
   logic              fifo_full, fifo_empty, push, pop;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   always_comb begin
      act_value = (RELU_EN && mac_data[DATA_W-1]) ? '0 : mac_data;
      pop       = !fifo_empty && !wr_stall;
      push      = (state_q == ST_RUN) && mac_valid && (!fifo_full || pop);
      acc_inc   = acc_q + ADDR_W'(1);
   end

   wb_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (act_value),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      nk_d    = nk_q;
      base_d  = base_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wre_d   = pop;
      // Any valid that is not pushed was either dropped or arrived out of RUN
      ovf_d   = ovf_q | (mac_valid && !push);

      if (pop) begin
         waddr_d = base_q + idx_q;
         wdata_d = fifo_rdata;
         idx_d   = idx_q + ADDR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (layer_start) begin
               nk_d    = Nk;
               base_d  = write_base;
               acc_d   = '0;
               idx_d   = '0;
               state_d = (Nk == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (push) begin
               acc_d = acc_inc;
               if (acc_inc == nk_q)
                  state_d = ST_DRAIN;
            end
         end
         // An empty FIFO means the final pop already issued on an earlier edge
         ST_DRAIN: begin
            if (fifo_count == '0)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         nk_q    <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         wre_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nk_q    <= nk_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         wre_q   <= wre_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wre           = wre_q;
   assign write_address = waddr_q;
   assign write_data    = wdata_q;
   assign busy          = busy_q;
   assign layer_done    = done_q;
   assign overflow_err  = ovf_q;

endmodule

`default_nettype wire
